// File: rtl/rijndael_pkg.sv
// Shared definitions for the Rijndael key-expansion slice: FSM states,
// round-key index width, the AES S-box and small GF(2^8) helpers.
package rijndael_pkg;

    localparam int RK_IDX_W = 4;

    typedef enum logic [0:0] {
        IDLE,
        RUN
    } keyexp_state_e;

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Number of cipher rounds for a key of nk 32-bit words.
    function automatic int nk2nr(input int nk);
        return nk + 6;
    endfunction

    // Multiply by x in GF(2^8) with the AES reduction polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte substitution through the S-box table.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[2047 - 8 * int'(b) -: 8];
    endfunction

    // Apply the S-box to each byte of a word.
    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

endpackage

// File: rtl/rijndael_keyschedulestep.sv
// One key-schedule step: from the current NK-word block and its round
// constant, produce the next NK expanded words. Word 0 sits in the MSBs.
module rijndael_keyschedulestep
    import rijndael_pkg::*;
#(
    parameter int NK = 4
) (
    input  logic [32*NK-1:0] i_words,
    input  logic [7:0]       i_rc,
    output logic [32*NK-1:0] o_next
);

    logic [31:0] w_prev;
    logic [31:0] w_temp;
    logic [31:0] w_word;

    // Ripple through the block: each new word depends on the one before it,
    // with RotWord/SubWord/Rcon on word 0 and the extra SubWord for 256-bit keys.
    always_comb begin
        o_next = '0;
        w_prev = i_words[31:0];
        w_temp = '0;
        w_word = '0;
        for (int j = 0; j < NK; j++) begin
            if (j == 0) begin
                w_temp = subWord({w_prev[23:0], w_prev[31:24]}) ^ {i_rc, 24'h000000};
            end else if (NK > 6 && j == 4) begin
                w_temp = subWord(w_prev);
            end else begin
                w_temp = w_prev;
            end
            w_word = i_words[32*(NK-1-j) +: 32] ^ w_temp;
            o_next[32*(NK-1-j) +: 32] = w_word;
            w_prev = w_word;
        end
    end

endmodule

// File: rtl/rijndael_keyexpansion.sv
// Sequential key-expansion engine. Loads a cipher key, then streams the
// NR+1 round keys over a valid/ready handshake, stepping the key schedule
// only when the 4-word output window runs past the current NK-word block.
module rijndael_keyexpansion
    import rijndael_pkg::*;
#(
    parameter int NK = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [32*NK-1:0]    key_i,
    input  logic                key_valid_i,
    output logic                key_ready_o,
    output logic [127:0]        rk_o,
    output logic [RK_IDX_W-1:0] rk_idx_o,
    output logic                rk_last_o,
    output logic                rk_valid_o,
    input  logic                rk_ready_i
);

    localparam int NR      = nk2nr(NK);
    localparam int KEYSIZE = 32 * NK;
    localparam logic [RK_IDX_W-1:0] LAST_IDX = RK_IDX_W'(NR);
    localparam logic [3:0]          NK_W     = 4'(NK);

    if (NK != 4 && NK != 6 && NK != 8) begin : g_badNk
        $error("rijndael_keyexpansion: NK must be 4, 6 or 8");
    end

    keyexp_state_e       r_state;
    logic [KEYSIZE-1:0]  r_cur;
    logic [2:0]          r_off;
    logic [7:0]          r_rc;
    logic [RK_IDX_W-1:0] r_idx;
    logic                r_valid;
    logic                r_last;
    logic                r_ready;

    logic [KEYSIZE-1:0]   w_next;
    logic [2*KEYSIZE-1:0] w_win;
    logic [127:0]         w_rk;
    logic [3:0]           w_offSum;

    rijndael_keyschedulestep #(.NK(NK)) u_step (
        .i_words (r_cur),
        .i_rc    (r_rc),
        .o_next  (w_next)
    );

    assign w_win    = {r_cur, w_next};
    assign w_offSum = {1'b0, r_off} + 4'd4;

    // Pick four consecutive words of the cur/next window; blank when no key is presented.
    always_comb begin
        w_rk = w_win[2*KEYSIZE - 1 - 32 * int'(r_off) -: 128];
        rk_o = r_valid ? w_rk : '0;
    end

    assign key_ready_o = r_ready;
    assign rk_valid_o  = r_valid;
    assign rk_idx_o    = r_idx;
    assign rk_last_o   = r_last;

    // Load a key when idle, then advance the window on every accepted round key.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_cur   <= '0;
            r_off   <= '0;
            r_rc    <= 8'h01;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (key_valid_i && r_ready) begin
                        r_cur   <= key_i;
                        r_off   <= '0;
                        r_rc    <= 8'h01;
                        r_idx   <= '0;
                        r_valid <= 1'b1;
                        r_last  <= 1'b0;
                        r_ready <= 1'b0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (rk_ready_i) begin
                        if (r_last) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_idx   <= '0;
                            r_ready <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_idx  <= r_idx + 1'b1;
                            r_last <= (r_idx + 1'b1) == LAST_IDX;
                            if (w_offSum >= NK_W) begin
                                r_cur <= w_next;
                                r_off <= 3'(w_offSum - NK_W);
                                r_rc  <= xtime(r_rc);
                            end else begin
                                r_off <= w_offSum[2:0];
                            end
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
